// File: rtl/reg_rename_if.sv
// Rename-stage bus between decode and the rename unit. Checkpoint controls
// exist only when RENAME_CHECKPOINT_EN is defined.
interface reg_rename_if #(
  parameter int PHYS_W   = 6,
  parameter int NUM_PHYS = 64
);
  logic              i_dec_valid;
  logic              i_uses_rs, i_uses_rt, i_uses_rw;
  logic [4:0]        i_rs_addr, i_rt_addr, i_rw_addr;
  logic              i_stall;
  logic              o_rename_valid;
  logic              o_uses_rs, o_uses_rt, o_uses_rw;
  logic [PHYS_W-1:0] o_rs_phys, o_rt_phys, o_rw_phys, o_old_rw_phys;
  logic              o_rename_stall;
  logic [NUM_PHYS-1:0] o_busy_bits;
  logic [5:0]        o_free_count;
  logic              i_wb_valid;
  logic [PHYS_W-1:0] i_wb_phys;
  logic              i_commit_valid;
  logic [PHYS_W-1:0] i_commit_old_phys;
`ifdef RENAME_CHECKPOINT_EN
  logic              i_ckpt_take, i_ckpt_restore;
`endif

  modport master (
`ifdef RENAME_CHECKPOINT_EN
    output i_ckpt_take, i_ckpt_restore,
`endif
    output i_dec_valid, i_uses_rs, i_uses_rt, i_uses_rw,
    output i_rs_addr, i_rt_addr, i_rw_addr, i_stall,
    output i_wb_valid, i_wb_phys, i_commit_valid, i_commit_old_phys,
    input  o_rename_valid, o_uses_rs, o_uses_rt, o_uses_rw,
    input  o_rs_phys, o_rt_phys, o_rw_phys, o_old_rw_phys,
    input  o_rename_stall, o_busy_bits, o_free_count
  );

  modport slave (
`ifdef RENAME_CHECKPOINT_EN
    input  i_ckpt_take, i_ckpt_restore,
`endif
    input  i_dec_valid, i_uses_rs, i_uses_rt, i_uses_rw,
    input  i_rs_addr, i_rt_addr, i_rw_addr, i_stall,
    input  i_wb_valid, i_wb_phys, i_commit_valid, i_commit_old_phys,
    output o_rename_valid, o_uses_rs, o_uses_rt, o_uses_rw,
    output o_rs_phys, o_rt_phys, o_rw_phys, o_old_rw_phys,
    output o_rename_stall, o_busy_bits, o_free_count
  );
endinterface

// File: rtl/reg_rename_unit.sv
// Register rename: map table, circular free list, busy vector, 1-cycle output reg.
// Optional branch checkpoint/restore of map + free-list head: RENAME_CHECKPOINT_EN.
module reg_rename_unit #(
  parameter int NUM_ARCH = 32,
  parameter int NUM_PHYS = 64,
  parameter int PHYS_W   = 6,
  parameter int FL_DEPTH = 32
) (
  input logic         clk,
  input logic         rst,
  reg_rename_if.slave rif
);
  localparam int FL_W  = $clog2(FL_DEPTH);
  localparam int CNT_W = FL_W + 1;

  logic [PHYS_W-1:0]   map_q [NUM_ARCH];
  logic [PHYS_W-1:0]   map_d [NUM_ARCH];
  logic [PHYS_W-1:0]   fl_q  [FL_DEPTH];
  logic [FL_W-1:0]     head_q, tail_q, head_inc;
  logic [CNT_W-1:0]    count_q;
  logic [NUM_PHYS-1:0] busy_q, busy_d;
  logic                needs_alloc, accept, alloc, commit_ok, restore;
  logic [PHYS_W-1:0]   alloc_tag;

  function automatic logic [FL_W-1:0] ptr_inc(input logic [FL_W-1:0] p);
    return (p == FL_W'(FL_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

`ifdef RENAME_CHECKPOINT_EN
  assign restore = rif.i_ckpt_restore;
`else
  assign restore = 1'b0;
`endif

  assign needs_alloc        = rif.i_uses_rw & (rif.i_rw_addr != 5'd0);
  assign rif.o_rename_stall = rif.i_dec_valid & needs_alloc & (count_q == '0);
  assign accept    = rif.i_dec_valid & ~rif.i_stall & ~rif.o_rename_stall & ~restore;
  assign alloc     = accept & needs_alloc;
  assign commit_ok = rif.i_commit_valid & (rif.i_commit_old_phys != '0) &
                     (count_q != CNT_W'(FL_DEPTH));
  assign alloc_tag = fl_q[head_q];
  assign head_inc  = ptr_inc(head_q);

  always_comb begin
    map_d = map_q;
    if (alloc) map_d[rif.i_rw_addr] = alloc_tag;
    map_d[0] = '0;
  end

  // Allocation set is applied after writeback clear so a same-tag set wins.
  always_comb begin
    busy_d = busy_q;
    if (rif.i_wb_valid) busy_d[rif.i_wb_phys] = 1'b0;
    if (alloc)          busy_d[alloc_tag]     = 1'b1;
    busy_d[0] = 1'b0;
  end

`ifdef RENAME_CHECKPOINT_EN
  logic [PHYS_W-1:0] snap_map [NUM_ARCH];
  logic [FL_W-1:0]   snap_head;
  logic [CNT_W-1:0]  ckpt_allocs;  // allocations since the snapshot, to rebuild count

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ARCH; i++) snap_map[i] <= PHYS_W'(i);
      snap_head   <= '0;
      ckpt_allocs <= '0;
    end else if (restore) begin
      ckpt_allocs <= '0;
    end else if (rif.i_ckpt_take) begin
      snap_map    <= map_d;
      snap_head   <= alloc ? head_inc : head_q;
      ckpt_allocs <= '0;
    end else if (alloc) begin
      ckpt_allocs <= ckpt_allocs + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ARCH; i++) map_q[i] <= PHYS_W'(i);
      for (int i = 0; i < FL_DEPTH; i++) fl_q[i]  <= PHYS_W'(NUM_ARCH + i);
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= CNT_W'(FL_DEPTH);
      busy_q  <= '0;
    end else begin
      busy_q <= busy_d;
      if (commit_ok) begin
        fl_q[tail_q] <= rif.i_commit_old_phys;
        tail_q       <= ptr_inc(tail_q);
      end
`ifdef RENAME_CHECKPOINT_EN
      if (restore) begin
        map_q   <= snap_map;
        head_q  <= snap_head;
        count_q <= count_q + CNT_W'(commit_ok) + ckpt_allocs;
      end else
`endif
      begin
        map_q   <= map_d;
        if (alloc) head_q <= head_inc;
        count_q <= count_q + CNT_W'(commit_ok) - CNT_W'(alloc);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rif.o_rename_valid <= 1'b0;
      rif.o_uses_rs      <= 1'b0;
      rif.o_uses_rt      <= 1'b0;
      rif.o_uses_rw      <= 1'b0;
      rif.o_rs_phys      <= '0;
      rif.o_rt_phys      <= '0;
      rif.o_rw_phys      <= '0;
      rif.o_old_rw_phys  <= '0;
    end else if (restore) begin
      rif.o_rename_valid <= 1'b0;
    end else if (!rif.i_stall) begin
      rif.o_rename_valid <= accept;
      if (accept) begin
        rif.o_uses_rs     <= rif.i_uses_rs;
        rif.o_uses_rt     <= rif.i_uses_rt;
        rif.o_uses_rw     <= rif.i_uses_rw;
        rif.o_rs_phys     <= map_q[rif.i_rs_addr];
        rif.o_rt_phys     <= map_q[rif.i_rt_addr];
        rif.o_rw_phys     <= alloc ? alloc_tag : '0;
        rif.o_old_rw_phys <= alloc ? map_q[rif.i_rw_addr] : '0;
      end
    end
  end

  assign rif.o_busy_bits  = busy_q;
  assign rif.o_free_count = 6'(count_q);

`ifndef SYNTHESIS
  a_no_overfree: assert property (@(posedge clk) disable iff (rst)
    !(rif.i_commit_valid && rif.i_commit_old_phys != '0 && count_q == CNT_W'(FL_DEPTH)));
`endif
endmodule

// File: doc/reg_rename_unit.md
Name: reg_rename_unit

Overview:
Rename-stage producer for the register-rename interface consumed by the forwarding/hazard logic. It maps architectural MIPS registers to physical registers through a map table, allocates destinations from a circular free list, and maintains the per-physical-register busy-bit vector. Busy bits are set on allocation and cleared on writeback. Old mappings are returned to the free list at commit. The block sits between decode and register-file read.

Parameters:
NUM_ARCH, 32, architectural registers; r0 never renamed
NUM_PHYS, 64, physical registers
PHYS_W, 6, physical tag width = $clog2(NUM_PHYS)
FL_DEPTH, 32, free-list depth = NUM_PHYS-NUM_ARCH

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
i_dec_valid  in  1  decoded instruction present
i_uses_rs / i_uses_rt / i_uses_rw  in  1 each  source/dest usage flags
i_rs_addr / i_rt_addr / i_rw_addr  in  5 each  architectural addresses
i_stall  in  1  downstream stall; hold output register
o_rename_valid  out  1  registered outputs hold a renamed instruction
o_uses_rs / o_uses_rt / o_uses_rw  out  1 each  registered copies of usage flags
o_rs_phys / o_rt_phys / o_rw_phys  out  PHYS_W each  physical tags
o_old_rw_phys  out  PHYS_W  prior mapping of rw, carried to commit
o_rename_stall  out  1  combinational: rename needed but free list empty
o_busy_bits  out  NUM_PHYS  busy vector, bit i = phys i pending write
o_free_count  out  6  free-list occupancy, 0..FL_DEPTH
i_wb_valid  in  1  writeback of a physical reg
i_wb_phys  in  PHYS_W  tag written back
i_commit_valid  in  1  commit; free old mapping
i_commit_old_phys  in  PHYS_W  tag to free

Behaviour:
- Reset (async, immediate): map[i]=i; free list holds 32..63 in order, head=0, tail=0, count=32; busy all 0; o_rename_valid=0; all tag outputs=0.
- needs_alloc = i_uses_rw & (i_rw_addr!=0).
- o_rename_stall = i_dec_valid & needs_alloc & (count==0).
- Accept = i_dec_valid & ~i_stall & ~o_rename_stall.
- Source lookup is combinational against the current map, so the incoming instruction's own dest update is not visible to its sources.
- On accept edge:
  - Output register loads rs_phys=map[rs], rt_phys=map[rt], uses flags, and o_rename_valid=1.
  - If needs_alloc: rw_phys=FL[head], old_rw_phys=map[rw], map[rw]<=FL[head], head++ (mod 32), count--, busy[FL[head]]<=1.
  - Else: rw_phys=0, old_rw_phys=0, no state change.
- Latency: 1 cycle, decode to o_*.
- i_stall=1: output register holds; map/free list unchanged.
- Not stalled and no accept: o_rename_valid<=0.
- i_wb_valid: busy[i_wb_phys]<=0. If same tag is allocated the same cycle, set wins.
- i_commit_valid with tag!=0: FL[tail]<=tag, tail++, count++.
- Commit with count==FL_DEPTH: ignored; simulation assertion fires.
- Alloc+commit same cycle: count unchanged, both pointers move. A freed tag is not allocatable until the next cycle (no bypass), so an empty-list stall persists that cycle.
- busy[0] and map[0] are constant 0.
- Pointers wrap modulo FL_DEPTH.

Optional Feature:
Macro RENAME_CHECKPOINT_EN.
- Enabled: adds ports i_ckpt_take (in 1) and i_ckpt_restore (in 1).
  - Take snapshots map table and post-update head in the same edge as a concurrent accept.
  - Restore loads map<=snapshot, head<=snapshot head, count<=(tail-head) mod 32 (32 when tail==head and list was full).
  - Restore also sets o_rename_valid<=0 and blocks accept that cycle. It has priority over take and accept. Commit/wb in the same cycle still apply.
  - Busy bits of reclaimed tags are left as-is and overwritten on reallocation.
- Disabled: ports absent, no snapshot storage.

Test Plan:
- Reset mid-operation after 5 renames -> immediately map[i]=i, count=32, busy=0, o_rename_valid=0.
- Rename add r3 <- r1,r2, then sub r4 <- r3,r1 -> first o_rw_phys=32, old=3; second o_rs_phys=32, o_rw_phys=33; busy[32],busy[33]=1.
- 32 back-to-back renames to r5 with no commits -> 33rd asserts o_rename_stall, o_rename_valid=0; commit of tag 5 releases stall the following cycle with o_rw_phys=5.
- Rename to r0 -> no allocation, o_rw_phys=0, count unchanged, busy unchanged.
- i_wb_valid with tag 32 plus simultaneous commit and alloc -> busy[32]=0, count unchanged, head and tail both advance.
- (RENAME_CHECKPOINT_EN) take at branch with r7->40, rename r7 twice (->41,42), restore -> map[7]=40, next alloc returns 41, o_free_count restored.
